// File: rtl/chorus_pkg.sv
// Shared types and constants for the chorus delay line.
package chorus_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned LFO_W       = 16;
  localparam int unsigned LAT_NEAREST = 5;
  localparam int unsigned LAT_INTERP  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdA,
    StRdAW,
    StRdB,
    StRdBW,
    StCalc,
    StOut
  } state_e;

endpackage

// File: rtl/delay_ram.sv
// Single-port sample memory with synchronous read; one access per cycle.
module delay_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/chorus_delay_line.sv
// Chorus: circular sample buffer read back at an LFO-modulated delay, mixed 50/50 with the dry input.
// Define CHORUS_INTERP_EN to interpolate linearly between the two taps around the fractional delay.
module chorus_delay_line
  import chorus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BASE_DELAY = 512,
  parameter int unsigned LFO_SHIFT  = 7
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       sampleValid_i,
  input  logic signed [LFO_W-1:0]    lfo_i,
  input  logic                       lfoValid_i,
  output logic signed [SAMPLE_W-1:0] sample_o,
  output logic                       sampleValid_o,
  output logic                       overrun_o
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned EXCURSION = 32768 >> LFO_SHIFT;
  localparam logic signed [SAMPLE_W:0] BASE_D = (SAMPLE_W + 1)'(BASE_DELAY);

  if (!((BASE_DELAY + EXCURSION + 1 < DEPTH) && (BASE_DELAY >= EXCURSION + 1))) begin : gen_bad_cfg
    $error("chorus_delay_line: delay excursion does not fit inside the buffer");
  end

  state_e                     state;
  logic [ADDR_W-1:0]          wp, rdAddr, ramAddr;
  logic [ADDR_W:0]            fill;
  logic signed [LFO_W-1:0]    lfoReg, lfoSnap, lfoShr;
  logic signed [SAMPLE_W-1:0] dry, tapA, ramRdata, wet;
  logic signed [SAMPLE_W:0]   delay, delayReg, fillNeed, fillExt, mixSum;
  logic                       fillOk, ramWe;

  // A coincident LFO update is used by the sample it arrives with.
  assign lfoSnap = lfoValid_i ? lfo_i : lfoReg;
  assign lfoShr  = lfoSnap >>> LFO_SHIFT;
  assign delay   = BASE_D + {lfoShr[LFO_W-1], lfoShr};
  assign fillExt = $signed((SAMPLE_W + 1)'(fill));

`ifdef CHORUS_INTERP_EN
  localparam int unsigned PROD_W = SAMPLE_W + 2 + LFO_SHIFT;

  logic [LFO_SHIFT-1:0]       fracReg;
  logic signed [SAMPLE_W-1:0] tapB, wetInterp, wetCalc;
  logic signed [SAMPLE_W:0]   diff;
  logic signed [PROD_W-1:0]   diffX, fracX, prod;

  assign fillNeed = delayReg + (SAMPLE_W + 1)'(1);
  assign diff     = {tapB[SAMPLE_W-1], tapB} - {tapA[SAMPLE_W-1], tapA};
  assign diffX    = {{(PROD_W - SAMPLE_W - 1){diff[SAMPLE_W]}}, diff};
  assign fracX    = {{(PROD_W - LFO_SHIFT){1'b0}}, fracReg};
  assign prod     = diffX * fracX;
  // Result lies between A and B, so 16-bit wrap-around arithmetic is exact.
  assign wetCalc  = SAMPLE_W'(prod >>> LFO_SHIFT) + tapA;
  assign wet      = fillOk ? wetInterp : '0;
`else
  assign fillNeed = delayReg;
  assign wet      = fillOk ? tapA : '0;
`endif

  assign mixSum = {dry[SAMPLE_W-1], dry} + {wet[SAMPLE_W-1], wet};

  always_comb begin
    ramAddr = rdAddr;
    ramWe   = 1'b0;
    if (state == StWr) begin
      ramAddr = wp;
      ramWe   = 1'b1;
    end
`ifdef CHORUS_INTERP_EN
    if (state == StRdB) begin
      ramAddr = rdAddr - 1'b1;
    end
`endif
  end

  delay_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(SAMPLE_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ramWe),
    .addr_i (ramAddr),
    .wdata_i(dry),
    .rdata_o(ramRdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state         <= StIdle;
      wp            <= '0;
      fill          <= '0;
      lfoReg        <= '0;
      sample_o      <= '0;
      sampleValid_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      sampleValid_o <= 1'b0;
      overrun_o     <= sampleValid_i && (state != StIdle);
      if (lfoValid_i) begin
        lfoReg <= lfo_i;
      end
      case (state)
        StIdle: begin
          if (sampleValid_i) begin
            dry      <= sample_i;
            delayReg <= delay;
`ifdef CHORUS_INTERP_EN
            fracReg  <= lfoSnap[LFO_SHIFT-1:0];
`endif
            state    <= StWr;
          end
        end
        StWr: begin
          wp     <= wp + 1'b1;
          rdAddr <= wp - delayReg[ADDR_W-1:0];
          // Gate on writes made before this one; stale RAM is never mixed in.
          fillOk <= fillExt >= fillNeed;
          if (fill != (ADDR_W + 1)'(DEPTH)) begin
            fill <= fill + 1'b1;
          end
          state  <= StRdA;
        end
        StRdA: state <= StRdAW;
        StRdAW: begin
          tapA <= ramRdata;
`ifdef CHORUS_INTERP_EN
          state <= StRdB;
`else
          state <= StOut;
`endif
        end
`ifdef CHORUS_INTERP_EN
        StRdB: state <= StRdBW;
        StRdBW: begin
          tapB  <= ramRdata;
          state <= StCalc;
        end
        StCalc: begin
          wetInterp <= wetCalc;
          state     <= StOut;
        end
`endif
        StOut: begin
          sample_o      <= SAMPLE_W'(mixSum >>> 1);
          sampleValid_o <= 1'b1;
          state         <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_chorus_delay_line.sv
// Bench for chorus_delay_line: sample-history reference model checked every cycle, plus literal anchors.
module tb_chorus_delay_line;
  import chorus_pkg::*;

`ifdef CHORUS_INTERP_EN
  localparam int LAT = LAT_INTERP;
  localparam bit INTERP = 1'b1;
`else
  localparam int LAT = LAT_NEAREST;
  localparam bit INTERP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic signed [15:0] sample;
  logic               sv;
  logic signed [15:0] lfo;
  logic               lv;
  logic signed [15:0] sample_o;
  logic               sampleValid_o;
  logic               overrun_o;

  chorus_delay_line dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .sample_i     (sample),
    .sampleValid_i(sv),
    .lfo_i        (lfo),
    .lfoValid_i   (lv),
    .sample_o     (sample_o),
    .sampleValid_o(sampleValid_o),
    .overrun_o    (overrun_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: output n mixes x[n] with x[n-D] (and x[n-D-1] when interpolating).
  int cyc = 0;
  int hist[2048];
  int nWr, lfoM, busyEnd, pendCyc, pendOut, expOut;
  bit expValid, expOv;

  always @(posedge clk) begin
    int snap, d, frac, n, a, b, wet, need;
    cyc++;
    expValid = 1'b0;
    expOv = 1'b0;
    if (!rst_n) begin
      nWr = 0; lfoM = 0; busyEnd = 0; pendCyc = -1; expOut = 0;
    end else begin
      if (pendCyc == cyc) begin
        expValid = 1'b1;
        expOut = pendOut;
      end
      if (sv) begin
        if (cyc < busyEnd) begin
          expOv = 1'b1;
        end else begin
          snap = lv ? int'(lfo) : lfoM;
          d = 512 + (snap >>> 7);
          frac = snap & 127;
          n = nWr;
          need = INTERP ? d + 1 : d;
          wet = 0;
          if (n >= need) begin
            a = hist[(n - d) & 2047];
            if (INTERP) begin
              b = hist[(n - d - 1) & 2047];
              wet = a + (((b - a) * frac) >>> 7);
            end else begin
              wet = a;
            end
          end
          pendOut = (int'(sample) + wet) >>> 1;
          hist[n & 2047] = int'(sample);
          nWr++;
          pendCyc = cyc + LAT - 1;
          busyEnd = cyc + LAT;
        end
      end
      if (lv) lfoM = int'(lfo);
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      total++;
      if (sampleValid_o !== expValid || overrun_o !== expOv || int'(sample_o) != expOut) begin
        bad++;
        $display("FAIL cycle %0d outputs: got valid=%0b ovr=%0b out=%0d, expected valid=%0b ovr=%0b out=%0d",
                 cyc, sampleValid_o, overrun_o, sample_o, expValid, expOv, expOut);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int litFor(input int id, input int n);
    if (id == 1 && n == 100) return 50;
    if (id == 1 && n == 511) return 255;
    if (id == 1 && n == 600) return 344;
    if (id == 1 && n == 1000) return 872;
    if (id == 2 && n == 1000) return 616;
    if (id == 2 && n == 1030) return 774;
    if (id == 3 && n == 1000) return INTERP ? 2975 : 2976;
    return -1;
  endfunction

  task automatic pulseReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic runRamp(input int id, input int scale, input int special, input int lastN);
    int lit, w, vcnt, ocnt;
    for (int n = 0; n <= lastN; n++) begin
      if (id == 1 && n == 5) begin
        sample = 16'(scale * n);
        sv = 1'b1;
        tick();
        sv = 1'b0;
        vcnt = 0;
        ocnt = 0;
        for (int i = 1; i <= 12; i++) begin
          vcnt += int'(sampleValid_o);
          ocnt += int'(overrun_o);
          sv = (i == 3);
          if (i == 3) sample = 16'h7eef;
          tick();
        end
        sv = 1'b0;
        check("overrun pulse count", ocnt, 1);
        check("valid pulses around overrun", vcnt, 1);
        continue;
      end
      sample = 16'(scale * n);
      sv = 1'b1;
      if (n == 1000) begin
        lv = 1'b1;
        lfo = 16'(special);
      end else if (n == 1001) begin
        lv = 1'b1;
        lfo = 16'sd0;
      end
      tick();
      sv = 1'b0;
      lv = 1'b0;
      lit = litFor(id, n);
      if (lit >= 0) begin
        w = 1;
        while (!sampleValid_o && w < 20) begin
          tick();
          w++;
        end
        check($sformatf("latency ramp%0d n=%0d", id, n), w, LAT);
        check($sformatf("output ramp%0d n=%0d", id, n), int'(sample_o), lit);
        tick();
      end else begin
        repeat ((n < 4) ? 135 : LAT - 1 + int'($urandom_range(0, 3))) tick();
      end
    end
    repeat (LAT + 2) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    sv = 1'b0;
    lv = 1'b0;
    sample = '0;
    lfo = '0;
    repeat (5) tick();
    check("reset sample_o", int'(sample_o), 0);
    check("reset sampleValid_o", int'(sampleValid_o), 0);
    check("reset overrun_o", int'(overrun_o), 0);
    rst_n = 1'b1;
    tick();

    // Abort a sample in flight: reset lands while the first read is issued.
    sample = 16'sd1234;
    sv = 1'b1;
    tick();
    sv = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();

    runRamp(1, 1, -32768, 1000);
    pulseReset();
    runRamp(2, 1, 32767, 1030);
    pulseReset();
    runRamp(3, 4, 64, 1000);
    pulseReset();

    // Random traffic: random samples, LFO words, spacing (including overruns) and resets.
    for (int it = 0; it < 2500; it++) begin
      sample = 16'($urandom);
      sv = 1'b1;
      lv = ($urandom_range(0, 3) == 0);
      lfo = 16'($urandom);
      tick();
      sv = 1'b0;
      lv = 1'b0;
      repeat ($urandom_range(0, LAT + 2)) begin
        lv = ($urandom_range(0, 7) == 0);
        lfo = 16'($urandom);
        tick();
      end
      lv = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    repeat (LAT + 4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
